// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU and EX/MEM pipeline register
module ex_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        EXMEMFlush,
   input  logic        RegWrite_EX,
   input  logic        MemtoReg_EX,
   input  logic        ALUSrc_EX,
   input  logic        MemWrite_EX,
   input  logic        RegDst_EX,
   input  logic        MemRead_EX,
   input  logic [1:0]  ALUOp_EX,
   input  logic [31:0] Readdata1_EX,
   input  logic [31:0] Readdata2_EX,
   input  logic [31:0] Signextend_EX,
   input  logic [4:0]  Rs_EX,
   input  logic [4:0]  Rt_EX,
   input  logic [4:0]  Rd_EX,
   input  logic        RegWrite_WB,
   input  logic [4:0]  WriteReg_WB,
   input  logic [31:0] WriteData_WB,
   output logic        RegWrite_MEM,
   output logic        MemtoReg_MEM,
   output logic        MemRead_MEM,
   output logic        MemWrite_MEM,
   output logic [31:0] ALUResult_MEM,
   output logic [31:0] WriteData_MEM,
   output logic [4:0]  WriteReg_MEM
);

   logic        mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic [31:0] fwd_a, fwd_b, alu_b, alu_result;
   logic [4:0]  write_reg;
   logic [5:0]  funct;
   logic [4:0]  shamt;

   // Register 0 is hardwired to zero, so it never takes a forwarded value.
   assign mem_hit_a = RegWrite_MEM && (WriteReg_MEM != 5'd0) && (WriteReg_MEM == Rs_EX);
   assign mem_hit_b = RegWrite_MEM && (WriteReg_MEM != 5'd0) && (WriteReg_MEM == Rt_EX);
   assign wb_hit_a  = RegWrite_WB  && (WriteReg_WB  != 5'd0) && (WriteReg_WB  == Rs_EX);
   assign wb_hit_b  = RegWrite_WB  && (WriteReg_WB  != 5'd0) && (WriteReg_WB  == Rt_EX);

   assign funct     = Signextend_EX[5:0];
   assign shamt     = Signextend_EX[10:6];
   assign write_reg = RegDst_EX ? Rd_EX : Rt_EX;

   // Operand forwarding; the newer EX/MEM value wins over MEM/WB.
   always_comb begin
      fwd_a = Readdata1_EX;
      fwd_b = Readdata2_EX;
      if (mem_hit_a)     fwd_a = ALUResult_MEM;
      else if (wb_hit_a) fwd_a = WriteData_WB;
      if (mem_hit_b)     fwd_b = ALUResult_MEM;
      else if (wb_hit_b) fwd_b = WriteData_WB;
   end

   assign alu_b = ALUSrc_EX ? Signextend_EX : fwd_b;

   // ALU: ALUOp selects add/sub directly, or defers to funct for R-type.
   always_comb begin
      alu_result = 32'd0;
      case (ALUOp_EX)
         2'b01: alu_result = fwd_a - alu_b;
         2'b10: begin
            case (funct)
               6'b100000, 6'b100001: alu_result = fwd_a + alu_b;
               6'b100010, 6'b100011: alu_result = fwd_a - alu_b;
               6'b100100: alu_result = fwd_a & alu_b;
               6'b100101: alu_result = fwd_a | alu_b;
               6'b100110: alu_result = fwd_a ^ alu_b;
               6'b100111: alu_result = ~(fwd_a | alu_b);
               6'b101010: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
               6'b101011: alu_result = {31'd0, fwd_a < alu_b};
               6'b000000: alu_result = alu_b << shamt;
               6'b000010: alu_result = alu_b >> shamt;
               default:   alu_result = 32'd0;
            endcase
         end
         default: alu_result = fwd_a + alu_b;
      endcase
   end

   // EX/MEM register; reset and flush both load an all-zero bubble.
   always_ff @(posedge clock) begin
      if (reset || EXMEMFlush) begin
         RegWrite_MEM  <= 1'b0;
         MemtoReg_MEM  <= 1'b0;
         MemRead_MEM   <= 1'b0;
         MemWrite_MEM  <= 1'b0;
         ALUResult_MEM <= 32'd0;
         WriteData_MEM <= 32'd0;
         WriteReg_MEM  <= 5'd0;
      end else begin
         RegWrite_MEM  <= RegWrite_EX;
         MemtoReg_MEM  <= MemtoReg_EX;
         MemRead_MEM   <= MemRead_EX;
         MemWrite_MEM  <= MemWrite_EX;
         ALUResult_MEM <= alu_result;
         WriteData_MEM <= fwd_b;
         WriteReg_MEM  <= write_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage
module tb_ex_stage;

   logic        clock = 1'b0;
   logic        reset, EXMEMFlush;
   logic        RegWrite_EX, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX;
   logic [1:0]  ALUOp_EX;
   logic [31:0] Readdata1_EX, Readdata2_EX, Signextend_EX;
   logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
   logic        RegWrite_WB;
   logic [4:0]  WriteReg_WB;
   logic [31:0] WriteData_WB;
   logic        RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM;
   logic [31:0] ALUResult_MEM, WriteData_MEM;
   logic [4:0]  WriteReg_MEM;

   // control bundle order {RegWrite, MemtoReg, ALUSrc, MemWrite, RegDst, MemRead}
   localparam logic [5:0] C_RW  = 6'b100000;
   localparam logic [5:0] C_MTR = 6'b010000;
   localparam logic [5:0] C_SRC = 6'b001000;
   localparam logic [5:0] C_MW  = 6'b000100;
   localparam logic [5:0] C_RD  = 6'b000010;
   localparam logic [5:0] C_MR  = 6'b000001;

   typedef struct {
      logic [3:0]  ctl;   // {RegWrite, MemtoReg, MemRead, MemWrite}
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
   } exp_t;

   exp_t  sb[$];
   string sb_name[$];
   int    checks = 0;
   int    errors = 0;

   ex_stage dut (
      .clock(clock), .reset(reset), .EXMEMFlush(EXMEMFlush),
      .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX),
      .MemWrite_EX(MemWrite_EX), .RegDst_EX(RegDst_EX), .MemRead_EX(MemRead_EX),
      .ALUOp_EX(ALUOp_EX), .Readdata1_EX(Readdata1_EX), .Readdata2_EX(Readdata2_EX),
      .Signextend_EX(Signextend_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
      .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
      .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .MemRead_MEM(MemRead_MEM),
      .MemWrite_MEM(MemWrite_MEM), .ALUResult_MEM(ALUResult_MEM),
      .WriteData_MEM(WriteData_MEM), .WriteReg_MEM(WriteReg_MEM)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_ex(input logic [5:0] ctl, input logic [1:0] op,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      {RegWrite_EX, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX} = ctl;
      ALUOp_EX = op;
      Rs_EX = rs; Rt_EX = rt; Rd_EX = rd;
      Readdata1_EX = a; Readdata2_EX = b; Signextend_EX = imm;
   endtask

   task automatic drive_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
      RegWrite_WB = en; WriteReg_WB = r; WriteData_WB = d;
   endtask

   task automatic expect_out(input string nm, input logic [3:0] ctl, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [4:0] wr);
      exp_t e;
      e.ctl = ctl; e.alu = alu; e.wd = wd; e.wr = wr;
      sb.push_back(e);
      sb_name.push_back(nm);
   endtask

   // step: wait for the falling edge, then set flush/reset; inputs follow via drive_*
   task automatic step(input logic rst, input logic fl);
      @(negedge clock);
      reset = rst; EXMEMFlush = fl;
   endtask

   // Monitor: every edge that follows an issued vector produces one checked result.
   always begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         exp_t  e;
         string nm;
         e  = sb.pop_front();
         nm = sb_name.pop_front();
         chk({nm, "_ctl"}, {28'd0, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM},
             {28'd0, e.ctl});
         chk({nm, "_alu"}, ALUResult_MEM, e.alu);
         chk({nm, "_wd"},  WriteData_MEM, e.wd);
         chk({nm, "_wr"},  {27'd0, WriteReg_MEM}, {27'd0, e.wr});
      end
   end

   initial begin
      reset = 1'b1; EXMEMFlush = 1'b0;
      drive_ex(C_RW | C_RD | C_MR | C_MTR | C_MW, 2'b10, 5'd5, 5'd7, 5'd3, 32'd10, 32'd20, 32'h20);
      drive_wb(1'b1, 5'd5, 32'h55);

      // reset held with nonzero inputs
      step(1, 0); expect_out("rst0", 4'h0, 32'd0, 32'd0, 5'd0);
      step(1, 0); expect_out("rst1", 4'h0, 32'd0, 32'd0, 5'd0);

      // add $3 = 10 + 20
      step(0, 0); drive_wb(0, 5'd0, 32'd0);
      drive_ex(C_RW | C_RD, 2'b00, 5'd5, 5'd7, 5'd3, 32'd10, 32'd20, 32'd0);
      expect_out("add", 4'b1000, 32'd30, 32'd20, 5'd3);
      // sub $4 = $3 - $1, $3 stale in register file -> MEM forward
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b01, 5'd3, 5'd1, 5'd4, 32'd0, 32'd4, 32'd0);
      expect_out("sub_fwd", 4'b1000, 32'd26, 32'd4, 5'd4);
      // $2 = 0x11
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b00, 5'd0, 5'd0, 5'd2, 32'h11, 32'd0, 32'd0);
      expect_out("set2", 4'b1000, 32'h11, 32'd0, 5'd2);
      // MEM and WB both target $2: MEM (0x11) wins
      step(0, 0); drive_wb(1, 5'd2, 32'h22);
      drive_ex(C_RW | C_RD, 2'b00, 5'd2, 5'd9, 5'd5, 32'h99, 32'd1, 32'd0);
      expect_out("prio", 4'b1000, 32'h12, 32'd1, 5'd5);
      // write to $0
      step(0, 0); drive_wb(0, 5'd0, 32'd0);
      drive_ex(C_RW | C_RD, 2'b00, 5'd6, 5'd6, 5'd0, 32'd1, 32'd2, 32'd0);
      expect_out("wr0", 4'b1000, 32'd3, 32'd2, 5'd0);
      // MEM and WB both target $0 -> register file used
      step(0, 0); drive_wb(1, 5'd0, 32'h22);
      drive_ex(C_RW | C_RD, 2'b00, 5'd0, 5'd0, 5'd7, 32'h40, 32'h5, 32'd0);
      expect_out("nofwd0", 4'b1000, 32'h45, 32'h5, 5'd7);
      // sw: base 0x100 + imm -4, rt from WB
      step(0, 0); drive_wb(1, 5'd9, 32'hDEAD);
      drive_ex(C_SRC | C_MW, 2'b00, 5'd8, 5'd9, 5'd0, 32'h100, 32'd0, 32'hFFFF_FFFC);
      expect_out("sw", 4'b0001, 32'hFC, 32'hDEAD, 5'd9);

      // funct sweep
      step(0, 0); drive_wb(0, 5'd0, 32'd0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'hFFFF_FFFF, 32'd1, 32'h2A);
      expect_out("slt", 4'b1000, 32'd1, 32'd1, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'hFFFF_FFFF, 32'd1, 32'h2B);
      expect_out("sltu", 4'b1000, 32'd0, 32'd1, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'h0, 32'd1, 32'h100);
      expect_out("sll", 4'b1000, 32'h10, 32'd1, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'h0, 32'h80, 32'h102);
      expect_out("srl", 4'b1000, 32'h8, 32'h80, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'h0, 32'h0, 32'h27);
      expect_out("nor", 4'b1000, 32'hFFFF_FFFF, 32'h0, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'd5, 32'd3, 32'h3F);
      expect_out("undef", 4'b1000, 32'd0, 32'd3, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'hF0F0, 32'hFF00, 32'h24);
      expect_out("and", 4'b1000, 32'hF000, 32'hFF00, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'hF0F0, 32'hFF00, 32'h25);
      expect_out("or", 4'b1000, 32'hFFF0, 32'hFF00, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'hF0F0, 32'hFF00, 32'h26);
      expect_out("xor", 4'b1000, 32'h0FF0, 32'hFF00, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b10, 5'd11, 5'd12, 5'd10, 32'd5, 32'd7, 32'h23);
      expect_out("subu", 4'b1000, 32'hFFFF_FFFE, 32'd7, 5'd10);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b11, 5'd11, 5'd12, 5'd10, 32'd1, 32'd2, 32'h3F);
      expect_out("op11", 4'b1000, 32'd3, 32'd2, 5'd10);

      // flush mid-stream
      step(0, 0);
      drive_ex(C_RW | C_MTR | C_MR | C_RD, 2'b00, 5'd11, 5'd12, 5'd13, 32'd100, 32'd1, 32'd0);
      expect_out("ld", 4'b1110, 32'd101, 32'd1, 5'd13);
      step(0, 1);
      drive_ex(C_RW | C_RD, 2'b00, 5'd11, 5'd12, 5'd13, 32'd7, 32'd7, 32'd0);
      expect_out("flush", 4'h0, 32'd0, 32'd0, 5'd0);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b00, 5'd13, 5'd12, 5'd14, 32'd50, 32'd2, 32'd0);
      expect_out("postflush", 4'b1000, 32'd52, 32'd2, 5'd14);
      // rt forwarded from MEM
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b01, 5'd0, 5'd14, 5'd15, 32'd100, 32'd0, 32'd0);
      expect_out("fwd_b", 4'b1000, 32'd48, 32'd52, 5'd15);
      // flush and reset together, then reset mid-stream
      step(1, 1);
      drive_ex(C_RW | C_RD, 2'b00, 5'd1, 5'd2, 5'd16, 32'd9, 32'd9, 32'd0);
      expect_out("rstflush", 4'h0, 32'd0, 32'd0, 5'd0);
      step(1, 0);
      expect_out("rstmid", 4'h0, 32'd0, 32'd0, 5'd0);
      step(0, 0);
      drive_ex(C_RW | C_RD, 2'b00, 5'd15, 5'd2, 5'd16, 32'd1, 32'd1, 32'd0);
      expect_out("postrst", 4'b1000, 32'd2, 32'd1, 5'd16);

      step(0, 0);
      drive_ex(6'd0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clock);
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the MEM stage. Resolves operand forwarding from EX/MEM and MEM/WB, decodes ALU control from `ALUOp_EX` and the funct field, and computes the ALU result. Registers everything needed downstream into an internal EX/MEM pipeline register with flush and synchronous reset.

## Interface
- No parameters; datapath is fixed at 32 bits and register indices at 5 bits.
- `clock`  in  1  Sole clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high; clears every EX/MEM register.
- `EXMEMFlush`  in  1  Loads a bubble (all zeros) into EX/MEM next edge.
- `RegWrite_EX, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX`  in  1 each  Control from ID/EX.
- `ALUOp_EX`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 add.
- `Readdata1_EX, Readdata2_EX`  in  32  Register-file operands rs and rt.
- `Signextend_EX`  in  32  Sign-extended immediate; bits [5:0] funct, [10:6] shamt.
- `Rs_EX, Rt_EX, Rd_EX`  in  5  Register indices.
- `RegWrite_WB`  in  1  MEM/WB write enable.
- `WriteReg_WB`  in  5  MEM/WB destination.
- `WriteData_WB`  in  32  Value being written back.
- `RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM`  out  1 each  Registered control.
- `ALUResult_MEM`  out  32  Registered ALU result.
- `WriteData_MEM`  out  32  Registered store data (forwarded rt).
- `WriteReg_MEM`  out  5  Registered destination index.

## Operation
- Destination: `RegDst_EX`=1 selects `Rd_EX`, else `Rt_EX`.
- Forwarding, evaluated independently for A (rs) and B (rt):
  - MEM hit when `RegWrite_MEM` & `WriteReg_MEM`≠0 & `WriteReg_MEM`==src. Value is `ALUResult_MEM`.
  - Else WB hit when `RegWrite_WB` & `WriteReg_WB`≠0 & `WriteReg_WB`==src. Value is `WriteData_WB`.
  - Else use the register-file value.
  - MEM has priority over WB. Register 0 is never forwarded.
  - Load-use hazards are stalled upstream; this block forwards `ALUResult_MEM` regardless of `MemtoReg_MEM`.
- Operand B is `Signextend_EX` when `ALUSrc_EX`=1, else the forwarded rt. Store data is always the forwarded rt.
- ALU control, with funct applied when `ALUOp_EX`=10:
  - 100000 and 100001: add
  - 100010 and 100011: sub
  - 100100: and; 100101: or; 100110: xor; 100111: nor
  - 101010: signed slt, result 0 or 1
  - 101011: unsigned sltu
  - 000000: sll B by shamt; 000010: srl B by shamt
  - Any other funct: result 0.
- Arithmetic is 32-bit modulo 2^32. No overflow trap.
- EX/MEM register update priority: `reset` > `EXMEMFlush` > load new values. Reset and flush both zero every output.

## Timing
- Forwarding, ALU and the destination mux are combinational within the cycle. Results appear at the EX/MEM outputs one clock after the ID/EX inputs are presented (latency 1, throughput 1 per cycle).
- Reset value of every output is 0, applied at the first rising edge with `reset`=1. Reset asserted mid-stream discards the in-flight instruction.
- Flush inserts exactly one bubble per asserted edge. Flush and reset asserted together behave as reset (identical result).
- Back-to-back dependent instructions: the MEM forward uses the registered `ALUResult_MEM` of the immediately preceding instruction in the same cycle, with no extra stall.
- There is no stall input. Upstream holds ID/EX and flushes this stage as required.

## Test plan
- Reset held 2 cycles while inputs are nonzero -> all outputs 0. After release, add with rs=5, rt=7 and operands 10/20 (`RegDst`=1, `Rd`=3) -> `ALUResult_MEM`=30 and `WriteReg_MEM`=3 one edge later.
- Dependent chain: add $3=10+20, then sub $4=$3−$1 ($1=4, register-file $3 stale at 0) -> second `ALUResult_MEM`=26 (MEM forward).
- Double hazard: MEM and WB both target $2 with 0x11 and 0x22 -> 0x11 is used (MEM priority). With `WriteReg`=0 on both -> register-file value used.
- sw with `ALUSrc`=1, imm=0xFFFFFFFC, base 0x100, rt forwarded from WB as 0xDEAD -> `ALUResult_MEM`=0xFC, `WriteData_MEM`=0xDEAD, `MemWrite_MEM`=1.
- funct sweep: slt with A=0xFFFFFFFF, B=1 gives 1, and sltu with the same operands gives 0. sll shamt 4 on 0x1 gives 0x10. nor 0/0 gives 0xFFFFFFFF. Undefined funct 0x3F gives 0.
- `EXMEMFlush` pulsed for one cycle mid-stream -> that cycle's outputs are all 0, and the following instruction passes through unaffected. Flush and reset asserted together -> all outputs 0.
